wb_scoreboard: RTL and testbench
================================

# wb_scoreboard

Register-hazard scoreboard and issue controller for the multi-cycle ysyxSoC pipeline. It sits between IDU issue and WBU writeback. It tracks in-flight writes to each GPR and throttles issue on RAW hazards, counter saturation and in-flight limits. It also serialises CSR, ecall, mret and ebreak instructions so that they issue only into an empty pipeline, clears all state on an exception redirect, and latches halt on ebreak.

## Interface
- CNT_W, 2, width of each per-register pending counter; saturation value is 2^CNT_W-1
- MAX_INFLIGHT, 4, maximum number of issued, uncommitted instructions
- INF_W, 3, width of the in-flight counter; must hold MAX_INFLIGHT
- clk  input  1  single clock; everything is posedge
- rst_n  input  1  asynchronous, active-low reset
- id_valid  input  1  IDU has an instruction to issue
- id_ready  output  1  scoreboard accepts the instruction; issue = id_valid && id_ready
- id_rs1, id_rs2  input  5 each  source register indices
- id_rs1_use, id_rs2_use  input  1 each  the source is actually read
- id_rd  input  5  destination register index
- id_wen  input  1  the instruction writes id_rd
- id_serial  input  1  CSR, ecall, mret or ebreak instruction
- wb_commit  input  1  WBU retires one instruction (one-cycle pulse)
- wb_rd  input  5  retiring destination register
- wb_wen  input  1  the retiring instruction wrote wb_rd
- flush  input  1  exception or mret redirect from WBU; all in-flight instructions are squashed
- halt  input  1  ebreak committed
- busy  output  1  inflight != 0
- inflight  output  INF_W  current in-flight count
- stall_cause  output  2  0 none, 1 RAW, 2 structural (saturated or full), 3 serial or halted
- sb_err  output  1  sticky; set when a commit underflows a counter

## Operation
- States: S_RUN, S_SERIAL, S_HALT. Reset state is S_RUN.
- Reset values: all counters 0; inflight 0; sb_err 0; with inflight 0 and S_RUN, id_ready evaluates to 1 and busy to 0.
- RAW: asserted when (id_rs1_use && id_rs1!=0 && cnt[id_rs1]!=0) or the same condition for rs2.
- Structural stall: asserted when (id_wen && id_rd!=0 && cnt[id_rd] saturated) or inflight==MAX_INFLIGHT.
- Serial stall: asserted when id_serial && inflight!=0.
- id_ready = state==S_RUN && !flush && !RAW && !structural && !serial_stall.
- stall_cause reports the highest-priority active cause: serial/halt, then RAW, then structural. It reads 0 when id_ready=1.
- Issue: if id_wen && id_rd!=0, cnt[id_rd]+1; inflight+1. If id_serial, next state is S_SERIAL.
- Commit: if wb_wen && wb_rd!=0, cnt[wb_rd]-1; inflight-1.
- Underflow: a commit against a zero counter or zero inflight holds that value at 0 and sets sb_err.
- Issue and commit in the same cycle to the same rd: counter unchanged. inflight is also unchanged when both events occur.
- S_SERIAL: id_ready=0. On wb_commit, go to S_RUN.
- flush: has priority over issue and commit in the same cycle. All counters and inflight go to 0. S_SERIAL goes to S_RUN; S_HALT stays.
- halt: enter S_HALT from any state. S_HALT is sticky until rst_n and forces id_ready=0. Counters continue to drain on commits.
- Register x0 is never tracked. Its counter is constant 0.

## Timing
- id_ready and stall_cause are combinational, from registered state and the id_* fields only.
- There is no combinational path from wb_* to id_ready. A RAW stall releases in the cycle after the wb_commit that clears it, which matches the WBU writing the register file in its S_COMMIT cycle.
- Counter, inflight and state updates take effect at the next posedge. busy and inflight are registered-derived.
- flush forces id_ready=0 combinationally in the flush cycle itself.
- Asserting rst_n low mid-operation clears everything immediately, asynchronously. Release must be synchronised externally.

## Structure
- Package sb_pkg holds:
  - state encodings S_RUN, S_SERIAL, S_HALT
  - stall_cause codes STALL_NONE, STALL_RAW, STALL_STRUCT, STALL_SERIAL
  - NUM_GPR=32
- Sub-module sb_cnt: one CNT_W saturating up/down counter with inc, dec and clr inputs and zero, sat and underflow outputs. It is instantiated for x1..x31.
- The top level holds the FSM, the inflight counter, hazard compare and stall_cause priority.

## Test plan
- Back-to-back dependency: issue rd=5 (addi), then offer rs1=5. Expect id_ready=0 and stall_cause=1. Pulse wb_commit with wb_rd=5; expect id_ready=1 in the following cycle, not the same cycle.
- Saturation and full, with CNT_W=2: issue three writes to x7 with no commits. The fourth x7 write sees stall_cause=2. A write to x8 issues; the fifth issue overall sees inflight=4 and stall_cause=2.
- Serialise: with inflight=2, offer id_serial=1 and expect stall_cause=3. Commit twice; it then issues and the state goes to S_SERIAL. The next instruction stalls until the serial instruction's wb_commit.
- Flush in the same cycle as issue and commit, with cnt[3]=1 and inflight=2: assert flush, id_valid and wb_commit together. Expect id_ready=0, then all counters 0, inflight=0 and busy=0 in the next cycle.
- Halt and x0: issue rd=0 with rs1=0 and expect no counter change and no RAW. Pulse halt; expect id_ready=0 permanently. rst_n low then clears to S_RUN with id_ready=1.
- Underflow: wb_commit with wb_wen=1 and wb_rd=9 while cnt[9]=0. Expect sb_err=1 sticky and the counter still 0.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared encodings for the writeback scoreboard: FSM states, stall-cause codes, GPR count.
// Pure declarations: no logic, no latency, no flow control.
package sb_pkg;

  localparam int NUM_GPR = 32;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_SERIAL = 2'd1,
    S_HALT   = 2'd2
  } sb_state_e;

  typedef enum logic [1:0] {
    STALL_NONE   = 2'd0,
    STALL_RAW    = 2'd1,
    STALL_STRUCT = 2'd2,
    STALL_SERIAL = 2'd3
  } stall_e;

endpackage

// File: rtl/sb_cnt.sv
// Per-GPR pending-write counter: saturating up/down with synchronous clear; updates at next posedge.
// No backpressure of its own; o_sat tells the issue logic to hold off, o_underflow flags a bad retire.
module sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_clr,
  output logic o_zero,
  output logic o_sat,
  output logic o_underflow
);

  logic [CNT_W-1:0] r_cnt;

  assign o_zero      = (r_cnt == '0);
  assign o_sat       = (r_cnt == '1);
  // A simultaneous issue and retire to the same register nets to zero, so it never underflows.
  assign o_underflow = i_dec && !i_inc && !i_clr && o_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && !o_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && !o_zero) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/wb_scoreboard.sv
// Register-hazard scoreboard between IDU issue and WBU writeback; id_ready is combinational from state and id_*.
// Holds id_ready low on RAW, saturation/full, serialisation or halt; state updates at the next posedge.
module wb_scoreboard
  import sb_pkg::*;
#(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int INF_W        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_use,
  input  logic             id_rs2_use,
  input  logic [4:0]       id_rd,
  input  logic             id_wen,
  input  logic             id_serial,
  input  logic             wb_commit,
  input  logic [4:0]       wb_rd,
  input  logic             wb_wen,
  input  logic             flush,
  input  logic             halt,
  output logic             busy,
  output logic [INF_W-1:0] inflight,
  output logic [1:0]       stall_cause,
  output logic             sb_err
);

  sb_state_e          r_state;
  sb_state_e          w_state_nxt;
  logic [INF_W-1:0]   r_inflight;
  logic               r_sb_err;

  logic [NUM_GPR-1:0] w_zero;
  logic [NUM_GPR-1:0] w_sat;
  logic [NUM_GPR-1:0] w_unf;
  logic               w_issue;
  logic               w_raw;
  logic               w_struct;
  logic               w_ser;
  logic               w_blocked;
  logic               w_inf_unf;

  // x0 is never tracked: permanently zero, never saturated, never underflows.
  assign w_zero[0] = 1'b1;
  assign w_sat[0]  = 1'b0;
  assign w_unf[0]  = 1'b0;

  for (genvar g = 1; g < NUM_GPR; g++) begin : g_cnt
    localparam logic [4:0] IDX = 5'(g);
    sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_inc       (w_issue && id_wen && (id_rd == IDX)),
      .i_dec       (wb_commit && wb_wen && (wb_rd == IDX)),
      .i_clr       (flush),
      .o_zero      (w_zero[g]),
      .o_sat       (w_sat[g]),
      .o_underflow (w_unf[g])
    );
  end

  assign w_raw     = (id_rs1_use && (id_rs1 != 5'd0) && !w_zero[id_rs1]) ||
                     (id_rs2_use && (id_rs2 != 5'd0) && !w_zero[id_rs2]);
  assign w_struct  = (id_wen && (id_rd != 5'd0) && w_sat[id_rd]) ||
                     (r_inflight == INF_W'(MAX_INFLIGHT));
  assign w_ser     = id_serial && (r_inflight != '0);
  assign w_blocked = (r_state != S_RUN);

  assign id_ready  = !w_blocked && !flush && !w_raw && !w_struct && !w_ser;
  assign w_issue   = id_valid && id_ready;

  always_comb begin
    stall_cause = STALL_NONE;
    if (!id_ready) begin
      if (w_blocked || w_ser) begin
        stall_cause = STALL_SERIAL;
      end else if (w_raw) begin
        stall_cause = STALL_RAW;
      end else if (w_struct) begin
        stall_cause = STALL_STRUCT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:    if (w_issue && id_serial) w_state_nxt = S_SERIAL;
      S_SERIAL: if (flush || wb_commit) w_state_nxt = S_RUN;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_RUN;
    endcase
    if (halt) begin
      w_state_nxt = S_HALT;
    end
  end

  assign w_inf_unf = wb_commit && !w_issue && !flush && (r_inflight == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
    end else if (flush) begin
      r_inflight <= '0;
    end else if (w_issue && !wb_commit) begin
      r_inflight <= r_inflight + 1'b1;
    end else if (wb_commit && !w_issue && (r_inflight != '0)) begin
      r_inflight <= r_inflight - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_err <= 1'b0;
    end else if (w_inf_unf || (|w_unf)) begin
      r_sb_err <= 1'b1;
    end
  end

  assign busy     = (r_inflight != '0);
  assign inflight = r_inflight;
  assign sb_err   = r_sb_err;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Scoreboard bench for wb_scoreboard: driver pushes model expectations, negedge monitor pops and compares.
module tb_wb_scoreboard;

  localparam int SAT_VAL = 3;
  localparam int MAX_INF = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_ready;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic       id_rs1_use, id_rs2_use, id_wen, id_serial;
  logic       wb_commit, wb_wen, flush, halt;
  logic       busy, sb_err;
  logic [2:0] inflight;
  logic [1:0] stall_cause;

  always #5 clk = ~clk;

  wb_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(4), .INF_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_use(id_rs1_use), .id_rs2_use(id_rs2_use),
    .id_rd(id_rd), .id_wen(id_wen), .id_serial(id_serial),
    .wb_commit(wb_commit), .wb_rd(wb_rd), .wb_wen(wb_wen),
    .flush(flush), .halt(halt),
    .busy(busy), .inflight(inflight), .stall_cause(stall_cause), .sb_err(sb_err)
  );

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1u;
    logic       rs2u;
    logic [4:0] rd;
    logic       wen;
    logic       serial;
    logic       commit;
    logic [4:0] wbrd;
    logic       wbwen;
    logic       flush;
    logic       halt;
  } stim_t;

  typedef struct {
    bit         ready;
    int         cause;
    int         inf;
    bit         busy;
    bit         err;
    string      tag;
  } exp_t;

  typedef struct {
    bit         wen;
    logic [4:0] rd;
  } ins_t;

  exp_t exp_q[$];
  exp_t mon_e;
  ins_t outst[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Reference model: pending writes per register, in-flight count, serial/halt flags.
  int   m_cnt[32];
  int   m_inf;
  bit   m_ser, m_halt, m_err;

  task automatic check(input string name, input int got, input int expv);
    n_checks++;
    if (got == expv) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, expv);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.tag, ".id_ready"},    int'(id_ready),    int'(mon_e.ready));
      check({mon_e.tag, ".stall_cause"}, int'(stall_cause), mon_e.cause);
      check({mon_e.tag, ".inflight"},    int'(inflight),    mon_e.inf);
      check({mon_e.tag, ".busy"},        int'(busy),        int'(mon_e.busy));
      check({mon_e.tag, ".sb_err"},      int'(sb_err),      int'(mon_e.err));
    end
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_inf = 0; m_ser = 0; m_halt = 0; m_err = 0;
    outst.delete();
  endtask

  task automatic apply(input stim_t s);
    id_valid = s.valid; id_rs1 = s.rs1; id_rs2 = s.rs2;
    id_rs1_use = s.rs1u; id_rs2_use = s.rs2u; id_rd = s.rd;
    id_wen = s.wen; id_serial = s.serial;
    wb_commit = s.commit; wb_rd = s.wbrd; wb_wen = s.wbwen;
    flush = s.flush; halt = s.halt;
  endtask

  task automatic step(input stim_t s, input string tag);
    exp_t e;
    bit raw, strc, ser, blk, rdy, iss;
    int d[32];
    int n;
    apply(s);
    raw  = (s.rs1u && s.rs1 != 0 && m_cnt[s.rs1] > 0) || (s.rs2u && s.rs2 != 0 && m_cnt[s.rs2] > 0);
    strc = (s.wen && s.rd != 0 && m_cnt[s.rd] == SAT_VAL) || (m_inf == MAX_INF);
    ser  = s.serial && (m_inf != 0);
    blk  = m_halt || m_ser;
    rdy  = !blk && !s.flush && !raw && !strc && !ser;
    e.ready = rdy;
    e.cause = rdy ? 0 : (blk || ser) ? 3 : raw ? 1 : strc ? 2 : 0;
    e.inf = m_inf; e.busy = (m_inf != 0); e.err = m_err; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    cyc++;
    if (s.flush) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_inf = 0; m_ser = 0;
      outst.delete();
    end else begin
      iss = s.valid && rdy;
      for (int r = 0; r < 32; r++) d[r] = 0;
      if (iss && s.wen && s.rd != 0) d[s.rd] += 1;
      if (s.commit && s.wbwen && s.wbrd != 0) d[s.wbrd] -= 1;
      for (int r = 0; r < 32; r++) begin
        n = m_cnt[r] + d[r];
        if (n < 0) begin m_err = 1; n = 0; end
        m_cnt[r] = n;
      end
      n = m_inf + int'(iss) - int'(s.commit);
      if (n < 0) begin m_err = 1; n = 0; end
      m_inf = n;
      if (m_ser && s.commit) m_ser = 0;
      else if (iss && s.serial) m_ser = 1;
      if (s.commit && outst.size() > 0) void'(outst.pop_front());
      if (iss) outst.push_back('{s.wen, s.rd});
    end
    if (s.halt) m_halt = 1;
    #1;
  endtask

  // Asynchronous reset asserted away from the clock edge; checked before release.
  task automatic do_reset();
    exp_t e;
    rst_n = 1'b0;
    apply(idle());
    model_reset();
    e.ready = 1; e.cause = 0; e.inf = 0; e.busy = 0; e.err = 0; e.tag = "reset";
    exp_q.push_back(e);
    @(posedge clk);
    cyc++;
    #1;
    rst_n = 1'b1;
  endtask

  function automatic stim_t with_commit(input stim_t s);
    stim_t t;
    t = s;
    if (outst.size() > 0) begin
      t.commit = 1'b1; t.wbrd = outst[0].rd; t.wbwen = outst[0].wen;
    end
    return t;
  endfunction

  function automatic stim_t rand_stim(input bit allow_halt);
    stim_t s;
    s = idle();
    s.valid  = ($urandom_range(0, 9) < 7);
    s.rs1    = 5'($urandom_range(0, 7));
    s.rs2    = 5'($urandom_range(0, 7));
    s.rs1u   = ($urandom_range(0, 1) == 1);
    s.rs2u   = ($urandom_range(0, 2) == 0);
    s.rd     = 5'($urandom_range(0, 7));
    s.wen    = ($urandom_range(0, 9) < 8);
    s.serial = ($urandom_range(0, 19) == 0);
    s.flush  = ($urandom_range(0, 49) == 0);
    s.halt   = allow_halt && ($urandom_range(0, 99) == 0);
    if ($urandom_range(0, 9) < 4) s = with_commit(s);
    return s;
  endfunction

  initial begin
    stim_t s;
    rst_n = 1'b0;
    apply(idle());
    @(posedge clk);
    #1;
    do_reset();
    step(idle(), "idle0");

    // Back-to-back dependency on x5.
    s = idle(); s.valid = 1; s.rd = 5; s.wen = 1; step(s, "dep_issue");
    s = idle(); s.valid = 1; s.rs1 = 5; s.rs1u = 1; step(s, "dep_raw");
    s = with_commit(s); step(s, "dep_commit_same_cyc");
    s = idle(); s.valid = 1; s.rs1 = 5; s.rs1u = 1; step(s, "dep_release");
    s = with_commit(idle()); step(s, "dep_drain");

    // Saturate x7, then fill the in-flight window.
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.valid = 1; s.rd = 7; s.wen = 1; step(s, "sat_issue");
    end
    s = idle(); s.valid = 1; s.rd = 7; s.wen = 1; step(s, "sat_stall");
    s = idle(); s.valid = 1; s.rd = 8; s.wen = 1; step(s, "sat_x8");
    s = idle(); s.valid = 1; s.rd = 9; s.wen = 1; step(s, "full_stall");
    for (int i = 0; i < 4; i++) step(with_commit(idle()), "sat_drain");

    // Serialisation behind two in-flight writes.
    s = idle(); s.valid = 1; s.rd = 10; s.wen = 1; step(s, "ser_pre");
    s.rd = 11; step(s, "ser_pre");
    s = idle(); s.valid = 1; s.serial = 1; step(s, "ser_wait");
    step(with_commit(s), "ser_wait_c1");
    step(with_commit(s), "ser_wait_c2");
    step(s, "ser_issue");
    s = idle(); s.valid = 1; s.rd = 14; s.wen = 1;
    step(s, "ser_block");
    step(s, "ser_block");
    step(with_commit(s), "ser_commit");
    step(s, "ser_after");
    step(with_commit(idle()), "ser_drain");

    // Flush colliding with issue and commit.
    s = idle(); s.valid = 1; s.rd = 3; s.wen = 1; step(s, "fl_pre");
    s.rd = 4; step(s, "fl_pre");
    s = idle(); s.valid = 1; s.rd = 12; s.wen = 1; s.flush = 1;
    step(with_commit(s), "fl_collide");
    s = idle(); s.valid = 1; s.rs1 = 3; s.rs1u = 1; s.rs2 = 4; s.rs2u = 1; step(s, "fl_after");
    step(with_commit(idle()), "fl_drain");

    // Underflow on x9 with nothing outstanding.
    s = idle(); s.commit = 1; s.wbrd = 9; s.wbwen = 1; step(s, "unf_commit");
    s = idle(); s.valid = 1; s.rs1 = 9; s.rs1u = 1; step(s, "unf_sticky");
    step(idle(), "unf_sticky2");

    // x0 handling and halt.
    do_reset();
    s = idle(); s.valid = 1; s.rs1 = 0; s.rs1u = 1; s.rd = 0; s.wen = 1; step(s, "x0_issue");
    s = idle(); s.valid = 1; s.rs1 = 0; s.rs1u = 1; s.rd = 13; s.wen = 1; step(with_commit(s), "x0_noraw");
    s = idle(); s.valid = 1; s.halt = 1; step(s, "halt_pulse");
    s = idle(); s.valid = 1;
    for (int i = 0; i < 3; i++) step(s, "halted");
    step(with_commit(s), "halt_drain");
    step(with_commit(s), "halt_drain");
    step(s, "halted_empty");
    do_reset();
    s = idle(); s.valid = 1; s.rd = 2; s.wen = 1; step(s, "post_halt");

    // Randomised traffic, async reset mid-stream, then traffic with occasional halt.
    for (int i = 0; i < 1500; i++) step(rand_stim(1'b0), "rnd");
    do_reset();
    for (int i = 0; i < 500; i++) step(rand_stim(1'b1), "rnd_h");

    apply(idle());
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
